// File: rtl/text_rom_arbiter.sv
// text_rom_arbiter
//   Shares one synchronous ascii_rom (11-bit address, 8-bit data, 1-cycle
//   registered read) among NREQ text overlay requesters. A new lookup can be
//   granted every clock. Each font row comes back two cycles after its grant,
//   tagged with a one-hot rvalid strobe for the requester that issued it.
//
// Ports
//   clk       pixel-domain clock, shared with ascii_rom
//   reset     asynchronous, active-high reset
//   req       per-requester lookup request (level)
//   req_addr  flattened ROM addresses, requester i at [11*i+10 : 11*i]
//   gnt       one-hot combinational grant, same cycle as req
//   rvalid    one-hot strobe; rdata belongs to that requester
//   rdata     font row returned from the ROM
//   rom_addr  registered address to ascii_rom
//   rom_data  ascii_rom output, valid one cycle after rom_addr
//   busy      a lookup is in stage 1 or stage 2
module text_rom_arbiter #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned IDW    = 3,
    parameter int unsigned HIPRI0 = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*11-1:0]   req_addr,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rvalid,
    output logic [7:0]           rdata,
    output logic [10:0]          rom_addr,
    input  logic [7:0]           rom_data,
    output logic                 busy
);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] win;
    logic           any_gnt;
    logic           rr_gnt;
    logic [10:0]    win_addr;

    logic           s1_valid, s2_valid;
    logic [IDW-1:0] s1_tag, s2_tag;

    // Winner selection: first requester at or after ptr, modulo NREQ. With
    // HIPRI0 set, requester 0 pre-empts the scan and never takes part in it.
    always_comb begin
        logic [NREQ-1:0] shifted;
        int unsigned     idx;
        any_gnt = 1'b0;
        rr_gnt  = 1'b0;
        win     = '0;
        shifted = '0;
        idx     = 0;
        if (HIPRI0 != 0 && req[0]) begin
            any_gnt = 1'b1;
        end else begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                idx = 32'(ptr_q) + k;
                if (idx >= NREQ) begin
                    idx = idx - NREQ;
                end
                shifted = req >> idx;
                if (!any_gnt && shifted[0] && !(HIPRI0 != 0 && idx == 0)) begin
                    any_gnt = 1'b1;
                    rr_gnt  = 1'b1;
                    win     = IDW'(idx);
                end
            end
        end
    end

    // Grant decode and winner address mux.
    always_comb begin
        gnt      = '0;
        win_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                gnt[i]   = any_gnt && !reset;
                win_addr = req_addr[11*i +: 11];
            end
        end
    end

    // Priority grants leave the pointer alone; only round-robin wins advance it.
    always_comb begin
        ptr_d = ptr_q;
        if (rr_gnt) begin
            ptr_d = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q    <= '0;
            rom_addr <= '0;
            s1_valid <= 1'b0;
            s1_tag   <= '0;
            s2_valid <= 1'b0;
            s2_tag   <= '0;
        end else begin
            ptr_q    <= ptr_d;
            s1_valid <= any_gnt;
            s1_tag   <= win;
            if (any_gnt) begin
                rom_addr <= win_addr;
            end
            // Stage 2 lines up with the ROM's own output register.
            s2_valid <= s1_valid;
            s2_tag   <= s1_tag;
        end
    end

    always_comb begin
        rvalid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rvalid[i] = s2_valid && (s2_tag == IDW'(i));
        end
    end

    // Zero outside a valid return so rdata reads 0 after reset.
    assign rdata = s2_valid ? rom_data : 8'h00;
    assign busy  = s1_valid | s2_valid;

endmodule

// File: tb/tb_text_rom_arbiter.sv
// Bench for text_rom_arbiter: a round-robin instance and a HIPRI0 instance,
// each with a behavioural 1-cycle ROM returning a known function of address.
module tb_text_rom_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [43:0] req_addr;
    logic [3:0]  gnt, rvalid, gnt_hp, rvalid_hp;
    logic [7:0]  rdata, rdata_hp, rom_data, rom_data_hp;
    logic [10:0] rom_addr, rom_addr_hp;
    logic        busy, busy_hp;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    text_rom_arbiter #(.NREQ(4), .IDW(3), .HIPRI0(0)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .gnt(gnt),
        .rvalid(rvalid), .rdata(rdata), .rom_addr(rom_addr), .rom_data(rom_data),
        .busy(busy)
    );

    text_rom_arbiter #(.NREQ(4), .IDW(3), .HIPRI0(1)) dut_hp (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .gnt(gnt_hp),
        .rvalid(rvalid_hp), .rdata(rdata_hp), .rom_addr(rom_addr_hp),
        .rom_data(rom_data_hp), .busy(busy_hp)
    );

    function automatic logic [7:0] font(input logic [10:0] a);
        return a[7:0] ^ {a[10:8], a[10:6]} ^ 8'h5a;
    endfunction

    function automatic logic [10:0] addr_of(input int i);
        return 11'h300 | 11'(i << 4) | 11'(i);
    endfunction

    always_ff @(posedge clk) begin
        rom_data    <= font(rom_addr);
        rom_data_hp <= font(rom_addr_hp);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'h0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [3:0] rv;
    } vec_t;

    vec_t tbl [15];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] hp_req [10];
        logic [3:0] hp_gnt [10];
        logic [10:0] ea;
        logic        eb;

        tbl[0]  = '{4'hF, 4'h1, 4'h0};
        tbl[1]  = '{4'hF, 4'h2, 4'h0};
        tbl[2]  = '{4'hF, 4'h4, 4'h1};
        tbl[3]  = '{4'hF, 4'h8, 4'h2};
        tbl[4]  = '{4'hF, 4'h1, 4'h4};
        tbl[5]  = '{4'hF, 4'h2, 4'h8};
        tbl[6]  = '{4'hF, 4'h4, 4'h1};
        tbl[7]  = '{4'hF, 4'h8, 4'h2};
        tbl[8]  = '{4'hA, 4'h2, 4'h4};
        tbl[9]  = '{4'hA, 4'h8, 4'h8};
        tbl[10] = '{4'hA, 4'h2, 4'h2};
        tbl[11] = '{4'hA, 4'h8, 4'h8};
        tbl[12] = '{4'h0, 4'h0, 4'h2};
        tbl[13] = '{4'h0, 4'h0, 4'h8};
        tbl[14] = '{4'h0, 4'h0, 4'h0};

        hp_req = '{4'h7, 4'h7, 4'h7, 4'h7, 4'h6, 4'h6, 4'h6, 4'h6, 4'h0, 4'h0};
        hp_gnt = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h4, 4'h2, 4'h4, 4'h0, 4'h0};

        // Reset state, gnt suppressed while reset is high.
        reset    = 1'b1;
        req      = 4'hF;
        req_addr = '0;
        #3;
        chk("rst_gnt", gnt, 4'h0);
        chk("rst_rom_addr", rom_addr, 11'h0);
        chk("rst_rvalid", rvalid, 4'h0);
        chk("rst_rdata", rdata, 8'h0);
        chk("rst_busy", busy, 1'b0);
        do_reset();

        // Single lookup by requester 0.
        @(negedge clk);
        req = 4'h1;
        req_addr[10:0] = 11'h301;
        #1;
        chk("t1_gnt", gnt, 4'h1);
        chk("t1_busy0", busy, 1'b0);
        @(negedge clk);
        req = 4'h0;
        #1;
        chk("t1_rom_addr", rom_addr, 11'h301);
        chk("t1_busy1", busy, 1'b1);
        chk("t1_rvalid_early", rvalid, 4'h0);
        @(negedge clk);
        #1;
        chk("t1_rvalid", rvalid, 4'h1);
        chk("t1_rdata", rdata, font(11'h301));
        chk("t1_busy2", busy, 1'b1);
        @(negedge clk);
        #1;
        chk("t1_rvalid_end", rvalid, 4'h0);
        chk("t1_busy_end", busy, 1'b0);
        chk("t1_rom_addr_hold", rom_addr, 11'h301);

        // All four requesting, then alternating 1 and 3 across the wrap.
        do_reset();
        for (int i = 0; i < 4; i++) req_addr[11*i +: 11] = addr_of(i);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            req = tbl[k].req;
            #1;
            chk($sformatf("tbl%0d_gnt", k), gnt, tbl[k].gnt);
            chk($sformatf("tbl%0d_rvalid", k), rvalid, tbl[k].rv);
            ea = '0;
            for (int i = 0; i < 4; i++) if (tbl[k].rv[i]) ea = addr_of(i);
            chk($sformatf("tbl%0d_rdata", k), rdata, (tbl[k].rv != 0) ? font(ea) : 8'h0);
            eb = 1'b0;
            if (k >= 1 && tbl[k-1].gnt != 0) eb = 1'b1;
            if (k >= 2 && tbl[k-2].gnt != 0) eb = 1'b1;
            chk($sformatf("tbl%0d_busy", k), busy, eb);
        end

        // Two grants in flight, then an asynchronous reset mid-cycle.
        @(negedge clk);
        req = 4'h1;
        @(negedge clk);
        req = 4'h2;
        @(negedge clk);
        req = 4'h0;
        #1;
        chk("t5_rvalid_pre", rvalid, 4'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rvalid_rst", rvalid, 4'h0);
        chk("t5_busy_rst", busy, 1'b0);
        chk("t5_rom_addr_rst", rom_addr, 11'h0);
        req = 4'hF;
        #1;
        chk("t5_gnt_rst", gnt, 4'h0);
        @(negedge clk);
        req   = 4'h0;
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("t5_post%0d_rvalid", k), rvalid, 4'h0);
            chk($sformatf("t5_post%0d_busy", k), busy, 1'b0);
        end

        // Same requester back-to-back at consecutive addresses.
        @(negedge clk);
        req = 4'h1;
        req_addr[10:0] = 11'h310;
        #1;
        chk("t6_gnt_a", gnt, 4'h1);
        @(negedge clk);
        req_addr[10:0] = 11'h311;
        #1;
        chk("t6_gnt_b", gnt, 4'h1);
        @(negedge clk);
        req = 4'h0;
        #1;
        chk("t6_rom_addr", rom_addr, 11'h311);
        chk("t6_rvalid_a", rvalid, 4'h1);
        chk("t6_rdata_a", rdata, font(11'h310));
        @(negedge clk);
        #1;
        chk("t6_rvalid_b", rvalid, 4'h1);
        chk("t6_rdata_b", rdata, font(11'h311));
        @(negedge clk);
        #1;
        chk("t6_rvalid_end", rvalid, 4'h0);

        // Requester 0 priority on the HIPRI0 instance; ptr untouched by it.
        do_reset();
        for (int i = 0; i < 4; i++) req_addr[11*i +: 11] = addr_of(i);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            req = hp_req[k];
            #1;
            chk($sformatf("hp%0d_gnt", k), gnt_hp, hp_gnt[k]);
            if (k >= 2) begin
                chk($sformatf("hp%0d_rvalid", k), rvalid_hp, hp_gnt[k-2]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
